// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two requesters and the shared-alu arbiter.
// master = requester side, slave = arbiter side.
interface alu_arbiter_if #(
  parameter int unsigned WORD_SIZE = 8
);
  logic                 req0_valid;
  logic                 req0_ready;
  logic [WORD_SIZE-1:0] req0_a;
  logic [WORD_SIZE-1:0] req0_b;
  logic                 req0_op;
  logic                 req1_valid;
  logic                 req1_ready;
  logic [WORD_SIZE-1:0] req1_a;
  logic [WORD_SIZE-1:0] req1_b;
  logic                 req1_op;
  logic                 rsp0_valid;
  logic                 rsp0_ready;
  logic [WORD_SIZE-1:0] rsp0_c;
  logic                 rsp1_valid;
  logic                 rsp1_ready;
  logic [WORD_SIZE-1:0] rsp1_c;

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_c, rsp1_valid, rsp1_c
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_c, rsp1_valid, rsp1_c
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational alu between two requesters;
// the alu result is registered and returned on the winner's response channel.
module alu_arbiter #(
  parameter int unsigned WORD_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_arbiter_if.slave         bus,
  output logic [WORD_SIZE-1:0] alu_a,
  output logic [WORD_SIZE-1:0] alu_b,
  output logic                 alu_op,
  input  logic [WORD_SIZE-1:0] alu_c
);

  localparam logic StIdle = 1'b0;
  localparam logic StHold = 1'b1;

  logic                 st_q;
  logic                 owner_q;
  logic                 last_grant_q;
  logic [WORD_SIZE-1:0] res_q;

  logic owner_ready;
  logic can_accept;
  logic grant_valid;
  logic grant_id;
  logic fire;

  always_comb begin
    owner_ready = owner_q ? bus.rsp1_ready : bus.rsp0_ready;
    // Ready is forced low during reset even though state is already at its reset value.
    can_accept  = !rst && ((st_q == StIdle) || owner_ready);
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_valid = 1'b1;
      grant_id    = ~last_grant_q;
    end else if (bus.req0_valid) begin
      grant_valid = 1'b1;
      grant_id    = 1'b0;
    end else if (bus.req1_valid) begin
      grant_valid = 1'b1;
      grant_id    = 1'b1;
    end
    fire = can_accept && grant_valid;
  end

  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = 1'b0;
    if (fire) begin
      if (grant_id) begin
        alu_a  = bus.req1_a;
        alu_b  = bus.req1_b;
        alu_op = bus.req1_op;
      end else begin
        alu_a  = bus.req0_a;
        alu_b  = bus.req0_b;
        alu_op = bus.req0_op;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q         <= StIdle;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      res_q        <= '0;
    end else if (fire) begin
      st_q         <= StHold;
      owner_q      <= grant_id;
      last_grant_q <= grant_id;
      res_q        <= alu_c;
    end else if ((st_q == StHold) && owner_ready) begin
      st_q <= StIdle;
    end
  end

  assign bus.req0_ready = fire && !grant_id;
  assign bus.req1_ready = fire && grant_id;
  assign bus.rsp0_valid = (st_q == StHold) && !owner_q;
  assign bus.rsp1_valid = (st_q == StHold) && owner_q;
  assign bus.rsp0_c     = owner_q ? '0 : res_q;
  assign bus.rsp1_c     = owner_q ? res_q : '0;

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized + directed bench for alu_arbiter with a queue-based scoreboard.
module tb_alu_arbiter;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       op;
  } op_t;

  typedef struct {
    bit         id;
    logic [7:0] c;
  } rsp_t;

  logic       clk;
  logic       rst;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_c;
  logic       alu_op;

  alu_arbiter_if #(.WORD_SIZE(8)) bus_if ();

  alu_arbiter #(.WORD_SIZE(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus_if.slave),
    .alu_a (alu_a),
    .alu_b (alu_b),
    .alu_op(alu_op),
    .alu_c (alu_c)
  );

  // The attached alu.
  always_comb alu_c = alu_op ? (alu_a - alu_b) : (alu_a + alu_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         hs0 = 0;
  int         hs1 = 0;
  logic [7:0] last_c0 = '0;
  logic [7:0] last_c1 = '0;
  bit         last_grant = 1'b1;
  bit         last_fire_id = 1'b0;
  op_t        opq0[$];
  op_t        opq1[$];
  rsp_t       sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_result(input op_t o);
    int t;
    t = o.op ? (int'(o.a) - int'(o.b) + 256) : (int'(o.a) + int'(o.b));
    return 8'(t % 256);
  endfunction

  // Monitor: whenever a result is owed, the owing channel must present it.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb[0];
        chk("rsp_valid", {30'd0, bus_if.rsp1_valid, bus_if.rsp0_valid},
            e.id ? 32'd2 : 32'd1);
        chk("rsp_c", e.id ? bus_if.rsp1_c : bus_if.rsp0_c, e.c);
        chk("rsp_c_other", e.id ? bus_if.rsp0_c : bus_if.rsp1_c, 0);
        if (e.id ? bus_if.rsp1_ready : bus_if.rsp0_ready) begin
          void'(sb.pop_front());
          if (e.id) begin
            hs1++;
            last_c1 = bus_if.rsp1_c;
          end else begin
            hs0++;
            last_c0 = bus_if.rsp0_c;
          end
        end
      end else begin
        chk("rsp_idle", {30'd0, bus_if.rsp1_valid, bus_if.rsp0_valid}, 0);
      end
    end
  end

  // One clock of stimulus plus the reference arbitration decision.
  task automatic cycle(input int p0, input int p1);
    bit   v0, v1, fire, g;
    op_t  f0, f1, w;
    rsp_t r;
    @(negedge clk);
    v0 = opq0.size() > 0;
    v1 = opq1.size() > 0;
    if (v0) f0 = opq0[0];
    else f0 = '{a: 8'($urandom), b: 8'($urandom), op: 1'($urandom)};
    if (v1) f1 = opq1[0];
    else f1 = '{a: 8'($urandom), b: 8'($urandom), op: 1'($urandom)};
    bus_if.req0_valid = v0;
    bus_if.req0_a     = f0.a;
    bus_if.req0_b     = f0.b;
    bus_if.req0_op    = f0.op;
    bus_if.req1_valid = v1;
    bus_if.req1_a     = f1.a;
    bus_if.req1_b     = f1.b;
    bus_if.req1_op    = f1.op;
    bus_if.rsp0_ready = $urandom_range(0, 99) < p0;
    bus_if.rsp1_ready = $urandom_range(0, 99) < p1;
    #2;
    // Nothing owed after this cycle's handshake means a new op can be taken.
    fire = (sb.size() == 0) && (v0 || v1);
    g    = (v0 && v1) ? ~last_grant : v1;
    chk("req0_ready", {31'd0, bus_if.req0_ready}, {31'd0, fire && !g});
    chk("req1_ready", {31'd0, bus_if.req1_ready}, {31'd0, fire && g});
    w = g ? f1 : f0;
    if (fire) chk("alu_in", {15'd0, alu_a, alu_b, alu_op}, {15'd0, w.a, w.b, w.op});
    else chk("alu_in_idle", {15'd0, alu_a, alu_b, alu_op}, 0);
    if (fire) begin
      r.id = g;
      r.c  = ref_result(w);
      sb.push_back(r);
      last_grant   = g;
      last_fire_id = g;
      if (g) void'(opq1.pop_front());
      else void'(opq0.pop_front());
    end
  endtask

  task automatic pulse_reset();
    #1;
    rst = 1'b1;
    bus_if.req0_valid = 1'b0;
    bus_if.req1_valid = 1'b0;
    #1;
    chk("async_rst_rsp_valid", {30'd0, bus_if.rsp1_valid, bus_if.rsp0_valid}, 0);
    chk("async_rst_rsp_c", {16'd0, bus_if.rsp1_c, bus_if.rsp0_c}, 0);
    sb.delete();
    opq0.delete();
    opq1.delete();
    last_grant = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    int base;
    rst = 1'b1;
    bus_if.req0_valid = 1'b1;
    bus_if.req1_valid = 1'b1;
    bus_if.req0_a = 8'd1; bus_if.req0_b = 8'd2; bus_if.req0_op = 1'b0;
    bus_if.req1_a = 8'd3; bus_if.req1_b = 8'd4; bus_if.req1_op = 1'b1;
    bus_if.rsp0_ready = 1'b1;
    bus_if.rsp1_ready = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_req_ready", {30'd0, bus_if.req1_ready, bus_if.req0_ready}, 0);
    chk("rst_rsp_valid", {30'd0, bus_if.rsp1_valid, bus_if.rsp0_valid}, 0);
    chk("rst_rsp_c", {16'd0, bus_if.rsp1_c, bus_if.rsp0_c}, 0);
    chk("rst_alu", {15'd0, alu_a, alu_b, alu_op}, 0);
    bus_if.req0_valid = 1'b0;
    bus_if.req1_valid = 1'b0;
    #1;
    rst = 1'b0;

    // Ties alternate starting with requester 0.
    for (int i = 0; i < 4; i++) begin
      opq0.push_back('{a: 8'd10, b: 8'd4, op: 1'b1});
      opq1.push_back('{a: 8'd200, b: 8'd100, op: 1'b0});
    end
    repeat (10) cycle(100, 100);
    chk("tie_hs0", hs0, 4);
    chk("tie_hs1", hs1, 4);
    chk("sub_10_4", {24'd0, last_c0}, 6);
    chk("add_wrap_200_100", {24'd0, last_c1}, 44);

    opq0.push_back('{a: 8'd5, b: 8'd3, op: 1'b0});
    repeat (3) cycle(100, 100);
    chk("add_5_3", {24'd0, last_c0}, 8);

    opq1.push_back('{a: 8'd3, b: 8'd5, op: 1'b1});
    repeat (3) cycle(100, 100);
    chk("sub_underflow", {24'd0, last_c1}, 254);

    // Back-pressure on requester 0 with requester 1 waiting.
    opq0.push_back('{a: 8'd77, b: 8'd9, op: 1'b0});
    opq1.push_back('{a: 8'd40, b: 8'd50, op: 1'b1});
    repeat (4) cycle(0, 100);
    repeat (4) cycle(100, 100);

    base = hs0;
    for (int i = 0; i < 8; i++)
      opq0.push_back('{a: 8'(i * 31 + 7), b: 8'(i * 13), op: 1'(i)});
    repeat (9) cycle(100, 100);
    chk("stream_8", hs0 - base, 8);

    // Reset while holding a result.
    opq0.push_back('{a: 8'd1, b: 8'd1, op: 1'b0});
    repeat (2) cycle(0, 0);
    pulse_reset();
    opq0.push_back('{a: 8'd20, b: 8'd2, op: 1'b0});
    opq1.push_back('{a: 8'd30, b: 8'd3, op: 1'b0});
    cycle(100, 100);
    chk("tie_after_reset", {31'd0, last_fire_id}, 0);
    repeat (3) cycle(100, 100);

    for (int i = 0; i < 400; i++) begin
      if (opq0.size() == 0 && $urandom_range(0, 99) < 60)
        opq0.push_back('{a: 8'($urandom), b: 8'($urandom), op: 1'($urandom)});
      if (opq1.size() == 0 && $urandom_range(0, 99) < 60)
        opq1.push_back('{a: 8'($urandom), b: 8'($urandom), op: 1'($urandom)});
      cycle(70, 70);
    end
    repeat (12) cycle(100, 100);
    chk("drain", sb.size() + opq0.size() + opq1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
